// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC register, synchronous imem address and a 16-entry BTB with 2-bit counters.
// Drives the C side of the C->D register; stall and fail_predict are the controls that register also sees.
module fetch_stage #(
  parameter logic [12:0] RESET_PC  = 13'd0,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        fail_predict,
  input  logic [12:0] redirect_pc,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [12:0] pcC,
  output logic [31:0] instC,
  output logic        predC,
  input  logic        upd_en,
  input  logic [12:0] upd_pc,
  input  logic        upd_taken,
  input  logic [12:0] upd_target
);
  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 11 - BTB_IDX_W;

  logic [12:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               pred_q, pred_d;

  logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
  logic [TAG_W-1:0]   btb_tag_d    [ENTRIES];
  logic [12:0]        btb_target_q [ENTRIES];
  logic [12:0]        btb_target_d [ENTRIES];
  logic [1:0]         btb_cnt_q    [ENTRIES];
  logic [1:0]         btb_cnt_d    [ENTRIES];

  logic [BTB_IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 lk_hit, lk_taken, up_hit;
  logic [12:0]          pred_pc;
  logic                 unused_upd_lsb;

  assign unused_upd_lsb = ^upd_pc[1:0];

  // A freshly reset stage has not presented pcC yet, so it re-issues it instead of advancing.
  always_comb begin
    lk_idx   = pc_q[BTB_IDX_W+1:2];
    lk_tag   = pc_q[12:BTB_IDX_W+2];
    lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && btb_cnt_q[lk_idx][1];
    pred_pc  = lk_taken ? btb_target_q[lk_idx] : pc_q + 13'd4;
    valid_d  = !RST;
    if (RST) begin
      pc_d   = RESET_PC;
      pred_d = 1'b0;
    end else if (fail_predict) begin
      pc_d   = redirect_pc;
      pred_d = 1'b0;
    end else if (stall || !valid_q) begin
      pc_d   = pc_q;
      pred_d = pred_q;
    end else begin
      pc_d   = pred_pc;
      pred_d = lk_taken;
    end
  end

  always_comb begin
    up_idx       = upd_pc[BTB_IDX_W+1:2];
    up_tag       = upd_pc[12:BTB_IDX_W+2];
    up_hit       = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_cnt_d    = btb_cnt_q;
    if (upd_en && !RST) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (btb_cnt_q[up_idx] != 2'd3) btb_cnt_d[up_idx] = btb_cnt_q[up_idx] + 2'd1;
          btb_target_d[up_idx] = upd_target;
        end else if (btb_cnt_q[up_idx] != 2'd0) begin
          btb_cnt_d[up_idx] = btb_cnt_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        btb_valid_d[up_idx]  = 1'b1;
        btb_tag_d[up_idx]    = up_tag;
        btb_target_d[up_idx] = upd_target;
        btb_cnt_d[up_idx]    = 2'd2;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      pred_q      <= 1'b0;
      btb_valid_q <= '0;
    end else begin
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      pred_q      <= pred_d;
      btb_valid_q <= btb_valid_d;
    end
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
    btb_cnt_q    <= btb_cnt_d;
  end

  // Address follows next_pc even while stalled so the held word is re-read.
  assign imem_addr = pc_d[12:2];
  assign pcC       = pc_q;
  assign predC     = pred_q;
  assign instC     = valid_q ? imem_rdata : 32'd0;
endmodule
